// File: rtl/spmv_sched_pkg.sv
// Shared constants, state encoding and skip-condition helper for the SpMV row scheduler.
package spmv_sched_pkg;

    localparam int unsigned K      = 4;
    localparam int unsigned DW     = 8 * K;
    localparam int unsigned ROWS_W = 8;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned PSUM_W = 28;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned LAT    = 5;
    localparam int unsigned TMO    = 15;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_DESC  = 3'd1;
    localparam state_t S_ISSUE = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_EMIT  = 3'd4;
    localparam state_t S_FIN   = 3'd5;

    // The pipeline never starts on a chunk whose leading matrix byte and IPV are both zero.
    function automatic logic skip_chunk(input logic [DW-1:0] mat, input logic [K-1:0] ipv);
        return (mat[DW-1 -: 8] == 8'h00) && (ipv == '0);
    endfunction

endpackage

// File: rtl/spmv_row_sched_if.sv
// Descriptor, chunk, pipeline and result buses of the SpMV row scheduler.
interface spmv_row_sched_if #(
    parameter int unsigned ROWS_W = spmv_sched_pkg::ROWS_W,
    parameter int unsigned LEN_W  = spmv_sched_pkg::LEN_W,
    parameter int unsigned PSUM_W = spmv_sched_pkg::PSUM_W,
    parameter int unsigned ACC_W  = spmv_sched_pkg::ACC_W
) ();
    import spmv_sched_pkg::*;

    logic              desc_valid;
    logic              desc_ready;
    logic [LEN_W-1:0]  desc_len;

    logic              chk_valid;
    logic              chk_ready;
    logic [DW-1:0]     chk_mat;
    logic [DW-1:0]     chk_vec;
    logic [K-1:0]      chk_ipv;

    logic              dp_issue;
    logic [DW-1:0]     dp_mat;
    logic [DW-1:0]     dp_vec;
    logic [K-1:0]      dp_ipv;
    logic              dp_out_valid;
    logic [PSUM_W-1:0] dp_sum;

    logic              res_valid;
    logic              res_ready;
    logic [ROWS_W-1:0] res_row;
    logic [ACC_W-1:0]  res_data;

    // Scheduler side.
    modport master (
        input  desc_valid, desc_len, output desc_ready,
        input  chk_valid, chk_mat, chk_vec, chk_ipv, output chk_ready,
        output dp_issue, dp_mat, dp_vec, dp_ipv,
        input  dp_out_valid, dp_sum,
        output res_valid, res_row, res_data, input res_ready
    );

    // Environment side: descriptor/chunk source, pipeline, result sink.
    modport slave (
        output desc_valid, desc_len, input desc_ready,
        output chk_valid, chk_mat, chk_vec, chk_ipv, input chk_ready,
        input  dp_issue, dp_mat, dp_vec, dp_ipv,
        output dp_out_valid, dp_sum,
        input  res_valid, res_row, res_data, output res_ready
    );

endinterface

// File: rtl/sat_acc.sv
// Signed saturating accumulator: sign-extends a PSUM_W addend into an ACC_W sum with sticky overflow flag.
module sat_acc #(
    parameter int unsigned PSUM_W = spmv_sched_pkg::PSUM_W,
    parameter int unsigned ACC_W  = spmv_sched_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_acc_i,
    input  logic              clr_sat_i,
    input  logic              add_i,
    input  logic [PSUM_W-1:0] din_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              sat_o
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic [ACC_W:0]   sum_c;
    logic             ovf_c;

    // One guard bit: overflow shows up as disagreement between the top two sum bits.
    assign sum_c = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PSUM_W){din_i[PSUM_W-1]}}, din_i};
    assign ovf_c = sum_c[ACC_W] ^ sum_c[ACC_W-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            if (clr_sat_i) sat_q <= 1'b0;
            if (clr_acc_i) begin
                acc_q <= '0;
            end else if (add_i) begin
                if (ovf_c) begin
                    acc_q <= sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
                    sat_q <= 1'b1;
                end else begin
                    acc_q <= sum_c[ACC_W-1:0];
                end
            end
        end
    end

    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/spmv_row_sched.sv
// Row scheduler: issues chunks one at a time into the SpMV pipeline and emits one saturated sum per row.
module spmv_row_sched #(
    parameter int unsigned ROWS_W = spmv_sched_pkg::ROWS_W,
    parameter int unsigned LEN_W  = spmv_sched_pkg::LEN_W,
    parameter int unsigned PSUM_W = spmv_sched_pkg::PSUM_W,
    parameter int unsigned ACC_W  = spmv_sched_pkg::ACC_W,
    parameter int unsigned TMO    = spmv_sched_pkg::TMO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ROWS_W-1:0]  n_rows,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               sat,
    spmv_row_sched_if.master   bus
);
    import spmv_sched_pkg::*;

    localparam int unsigned CNT_W = $clog2(TMO + 1);

    state_t            state_q, state_d;
    logic [ROWS_W-1:0] n_rows_q, n_rows_d;
    logic [ROWS_W-1:0] row_cnt_q, row_cnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic busy_q, done_q, desc_ready_q, chk_ready_q, dp_issue_q, res_valid_q;
    logic [DW-1:0] dp_mat_q, dp_vec_q;
    logic [K-1:0]  dp_ipv_q;

    logic desc_hs, chk_hs, res_hs, skip_c;
    logic clr_acc, clr_sat, add_en, issue_d, done_d;
    logic [ACC_W-1:0] acc;
    logic             sat_flag;

    assign desc_hs = desc_ready_q && bus.desc_valid;
    assign chk_hs  = chk_ready_q && bus.chk_valid;
    assign res_hs  = res_valid_q && bus.res_ready;
    assign skip_c  = skip_chunk(bus.chk_mat, bus.chk_ipv);

    always_comb begin
        state_d   = state_q;
        n_rows_d  = n_rows_q;
        row_cnt_d = row_cnt_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        clr_acc   = 1'b0;
        clr_sat   = 1'b0;
        add_en    = 1'b0;
        issue_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                n_rows_d  = n_rows;
                row_cnt_d = '0;
                err_d     = 1'b0;
                clr_sat   = 1'b1;
                state_d   = (n_rows == '0) ? S_FIN : S_DESC;
            end
            S_DESC: if (desc_hs) begin
                rem_d   = bus.desc_len;
                clr_acc = 1'b1;
                state_d = (bus.desc_len == '0) ? S_EMIT : S_ISSUE;
            end
            S_ISSUE: if (chk_hs) begin
                if (skip_c) begin
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? S_EMIT : S_ISSUE;
                end else begin
                    issue_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A timed-out chunk contributes nothing but still retires.
                if (bus.dp_out_valid || (cnt_q == CNT_W'(TMO))) begin
                    add_en  = bus.dp_out_valid;
                    err_d   = err_q | ~bus.dp_out_valid;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? S_EMIT : S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EMIT: if (res_hs) begin
                row_cnt_d = row_cnt_q + ROWS_W'(1);
                state_d   = (row_cnt_d == n_rows_q) ? S_FIN : S_DESC;
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            n_rows_q     <= '0;
            row_cnt_q    <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            desc_ready_q <= 1'b0;
            chk_ready_q  <= 1'b0;
            dp_issue_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            dp_mat_q     <= '0;
            dp_vec_q     <= '0;
            dp_ipv_q     <= '0;
        end else begin
            state_q      <= state_d;
            n_rows_q     <= n_rows_d;
            row_cnt_q    <= row_cnt_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= done_d;
            desc_ready_q <= (state_d == S_DESC);
            chk_ready_q  <= (state_d == S_ISSUE);
            dp_issue_q   <= issue_d;
            res_valid_q  <= (state_d == S_EMIT);
            if (chk_hs) begin
                dp_mat_q <= bus.chk_mat;
                dp_vec_q <= bus.chk_vec;
                dp_ipv_q <= bus.chk_ipv;
            end
        end
    end

    sat_acc #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr_acc_i (clr_acc),
        .clr_sat_i (clr_sat),
        .add_i     (add_en),
        .din_i     (bus.dp_sum),
        .acc_o     (acc),
        .sat_o     (sat_flag)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign sat            = sat_flag;
    assign bus.desc_ready = desc_ready_q;
    assign bus.chk_ready  = chk_ready_q;
    assign bus.dp_issue   = dp_issue_q;
    assign bus.dp_mat     = dp_mat_q;
    assign bus.dp_vec     = dp_vec_q;
    assign bus.dp_ipv     = dp_ipv_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_row    = row_cnt_q;
    assign bus.res_data   = acc;

endmodule

// File: tb/tb_spmv_row_sched.sv
// Directed bench for spmv_row_sched with a fixed-latency pipeline model and hand-computed row sums.
module tb_spmv_row_sched;

    localparam int unsigned RW  = 8;
    localparam int unsigned LW  = 6;
    localparam int unsigned PW  = 28;
    localparam int unsigned AW  = 28;
    localparam int unsigned DWB = 32;
    localparam int unsigned LATENCY = 5;
    localparam int unsigned TMO_C   = 15;

    logic clk = 1'b0;
    logic rst, start;
    logic [RW-1:0] n_rows;
    logic busy, done, err, sat;

    spmv_row_sched_if #(.ROWS_W(RW), .LEN_W(LW), .PSUM_W(PW), .ACC_W(AW)) bus ();

    spmv_row_sched #(.ROWS_W(RW), .LEN_W(LW), .PSUM_W(PW), .ACC_W(AW), .TMO(TMO_C)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n_rows (n_rows),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .sat    (sat),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int issue_cnt = 0, last_issue = 0, prev_issue = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dp_issue) begin
            issue_cnt  <= issue_cnt + 1;
            prev_issue <= last_issue;
            last_issue <= cyc;
        end
    end

    // Pipeline model: result strobe LATENCY cycles after dp_issue, sums taken in order.
    int sum_tbl[64];
    int sum_wr = 0;
    int sum_rd = 0;
    int pipe_fired = 0;
    bit pipe_en = 1'b1;

    initial begin
        int cd;
        cd = 0;
        bus.dp_out_valid = 1'b0;
        bus.dp_sum = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.dp_out_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && pipe_en) begin
                    bus.dp_out_valid = 1'b1;
                    bus.dp_sum = PW'(sum_tbl[sum_rd]);
                    sum_rd++;
                    pipe_fired++;
                end
            end
            if (bus.dp_issue) cd = LATENCY;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sum(input int v);
        sum_tbl[sum_wr] = v;
        sum_wr++;
    endtask

    task automatic do_start(input int n);
        n_rows = RW'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_desc(input int len);
        int w;
        w = 0;
        bus.desc_valid = 1'b1;
        bus.desc_len = LW'(len);
        while (!bus.desc_ready && w < 100) begin step(); w++; end
        check("desc_ready", 64'(bus.desc_ready), 64'(1));
        step();
        bus.desc_valid = 1'b0;
    endtask

    task automatic send_chk(input logic [DWB-1:0] mat, input logic [DWB-1:0] vec, input logic [3:0] ipv);
        int w;
        w = 0;
        bus.chk_valid = 1'b1;
        bus.chk_mat = mat;
        bus.chk_vec = vec;
        bus.chk_ipv = ipv;
        while (!bus.chk_ready && w < 100) begin step(); w++; end
        check("chk_ready", 64'(bus.chk_ready), 64'(1));
        step();
        bus.chk_valid = 1'b0;
    endtask

    task automatic get_res(input string tag, input int row, input logic [AW-1:0] data);
        int w;
        w = 0;
        bus.res_ready = 1'b1;
        while (!bus.res_valid && w < 100) begin step(); w++; end
        check({tag, "_valid"}, 64'(bus.res_valid), 64'(1));
        check({tag, "_row"}, 64'(bus.res_row), 64'(RW'(row)));
        check({tag, "_data"}, 64'(bus.res_data), 64'(data));
        step();
        bus.res_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (!done && w < 20) begin step(); w++; end
        check({tag, "_done"}, 64'(done), 64'(1));
        step();
    endtask

    initial begin
        int base;
        int fired0;
        rst = 1'b0;
        start = 1'b0;
        n_rows = '0;
        bus.desc_valid = 1'b0;
        bus.desc_len = '0;
        bus.chk_valid = 1'b0;
        bus.chk_mat = '0;
        bus.chk_vec = '0;
        bus.chk_ipv = '0;
        bus.res_ready = 1'b0;
        repeat (3) step();

        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_sat", 64'(sat), 64'(0));
        check("rst_desc_ready", 64'(bus.desc_ready), 64'(0));
        check("rst_chk_ready", 64'(bus.chk_ready), 64'(0));
        check("rst_dp_issue", 64'(bus.dp_issue), 64'(0));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_dp_mat", 64'(bus.dp_mat), 64'(0));
        rst = 1'b1;
        step();

        // Empty pass: straight to FIN, done one cycle after.
        do_start(0);
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_desc_ready", 64'(bus.desc_ready), 64'(0));
        check("t1_done_early", 64'(done), 64'(0));
        step();
        check("t1_done", 64'(done), 64'(1));
        check("t1_busy_off", 64'(busy), 64'(0));
        step();
        check("t1_done_pulse", 64'(done), 64'(0));

        // One row, two chunks: 100 + (-30) = 70, issues 7 cycles apart.
        base = issue_cnt;
        push_sum(100);
        push_sum(-30);
        do_start(1);
        check("t2_desc_ready", 64'(bus.desc_ready), 64'(1));
        send_desc(2);
        send_chk(32'hA1B2C3D4, 32'h01020304, 4'hF);
        check("t2_dp_issue", 64'(bus.dp_issue), 64'(1));
        check("t2_dp_mat", 64'(bus.dp_mat), 64'(32'hA1B2C3D4));
        send_chk(32'h11223344, 32'h05060708, 4'h3);
        get_res("t2", 0, AW'(70));
        check("t2_issues", 64'(issue_cnt - base), 64'(2));
        check("t2_period", 64'(last_issue - prev_issue), 64'(7));
        check("t2_ipv_held", 64'(bus.dp_ipv), 64'(4'h3));
        wait_done("t2");

        // Empty row then a one-chunk row.
        base = issue_cnt;
        push_sum(-5);
        do_start(2);
        send_desc(0);
        get_res("t3a", 0, AW'(0));
        send_desc(1);
        send_chk(32'h80000001, 32'h00000002, 4'h1);
        get_res("t3b", 1, AW'(-5));
        wait_done("t3");
        check("t3_issues", 64'(issue_cnt - base), 64'(1));

        // Skipped chunk (top byte 0, ipv 0) followed by a real one.
        base = issue_cnt;
        push_sum(9);
        do_start(1);
        send_desc(2);
        send_chk(32'h00112233, 32'h44556677, 4'h0);
        check("t4_skip_no_issue", 64'(bus.dp_issue), 64'(0));
        check("t4_skip_ready", 64'(bus.chk_ready), 64'(1));
        send_chk(32'h00112233, 32'h44556677, 4'h1);
        get_res("t4", 0, AW'(9));
        wait_done("t4");
        check("t4_issues", 64'(issue_cnt - base), 64'(1));

        // Positive saturation.
        push_sum('h7FFFFFF);
        push_sum('h7FFFFFF);
        push_sum('h7FFFFFF);
        do_start(1);
        send_desc(3);
        send_chk(32'h10000000, 32'h1, 4'h1);
        send_chk(32'h10000000, 32'h1, 4'h1);
        send_chk(32'h10000000, 32'h1, 4'h1);
        get_res("t5", 0, AW'('h7FFFFFF));
        check("t5_sat", 64'(sat), 64'(1));
        wait_done("t5");

        // Negative saturation; sat cleared on start.
        push_sum(-134217728);
        push_sum(-134217728);
        do_start(1);
        check("t5b_sat_clr", 64'(sat), 64'(0));
        send_desc(2);
        send_chk(32'hF0000000, 32'h1, 4'h2);
        send_chk(32'hF0000000, 32'h1, 4'h2);
        get_res("t5b", 0, AW'('h8000000));
        check("t5b_sat", 64'(sat), 64'(1));
        wait_done("t5b");

        // Withheld result: timeout sets err, row still emits zero.
        pipe_en = 1'b0;
        do_start(1);
        send_desc(1);
        send_chk(32'h55000000, 32'h1, 4'h8);
        check("t6_dp_issue", 64'(bus.dp_issue), 64'(1));
        repeat (10) step();
        check("t6_err_early", 64'(err), 64'(0));
        get_res("t6", 0, AW'(0));
        check("t6_err", 64'(err), 64'(1));
        wait_done("t6");
        pipe_en = 1'b1;

        // Reset mid-WAIT; the late result strobe must be ignored.
        push_sum(55);
        fired0 = pipe_fired;
        do_start(1);
        check("t7_err_clr", 64'(err), 64'(0));
        send_desc(1);
        send_chk(32'h66000000, 32'h1, 4'h4);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (4) step();
        check("t7_late_strobe", 64'(pipe_fired - fired0), 64'(1));
        check("t7_busy", 64'(busy), 64'(0));
        check("t7_res_valid", 64'(bus.res_valid), 64'(0));
        check("t7_chk_ready", 64'(bus.chk_ready), 64'(0));
        check("t7_desc_ready", 64'(bus.desc_ready), 64'(0));
        check("t7_dp_issue", 64'(bus.dp_issue), 64'(0));
        check("t7_dp_mat", 64'(bus.dp_mat), 64'(0));
        check("t7_err", 64'(err), 64'(0));
        check("t7_done", 64'(done), 64'(0));
        step();
        check("t7_busy_hold", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
